// File: rtl/cpu_decode_execute_pipe.sv
// Decode->execute stage boundary: a DEPTH-entry FIFO carrying the execute bundle,
// with load-use bubble insertion, synchronous flush and a saturating stall counter.
module cpu_decode_execute_pipe #(
   parameter  int REG_WIDTH   = 32,
   parameter  int VADDR_WIDTH = 32,
   parameter  int NUM_REGS    = 32,
   parameter  int NUM_ALU_OPS = 16,
   parameter  int MODE_W      = 2,
   parameter  int DEPTH       = 2,
   parameter  int CNT_W       = 16,
   localparam int ID_W        = $clog2(NUM_REGS),
   localparam int OP_W        = $clog2(NUM_ALU_OPS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   input  logic                   ex_valid,
   input  logic                   ex_mem_read,
   input  logic [ID_W-1:0]        ex_reg_dest,
   input  logic [OP_W-1:0]        in_alu_op,
   input  logic                   in_use_reg_b,
   input  logic                   in_mem_write,
   input  logic                   in_mem_read,
   input  logic [MODE_W-1:0]      in_cache_mode,
   input  logic                   in_mem_to_reg,
   input  logic                   in_reg_write,
   input  logic                   in_tlb_write,
   input  logic                   in_rm4,
   input  logic [VADDR_WIDTH-1:0] in_next_pc,
   input  logic [REG_WIDTH-1:0]   in_ra_data,
   input  logic [REG_WIDTH-1:0]   in_rb_data,
   input  logic [REG_WIDTH-1:0]   in_offset,
   input  logic [ID_W-1:0]        in_ra_id,
   input  logic [ID_W-1:0]        in_rb_id,
   input  logic [ID_W-1:0]        in_reg_dest,
   output logic [OP_W-1:0]        out_alu_op,
   output logic                   out_use_reg_b,
   output logic                   out_mem_write,
   output logic                   out_mem_read,
   output logic [MODE_W-1:0]      out_cache_mode,
   output logic                   out_mem_to_reg,
   output logic                   out_reg_write,
   output logic                   out_tlb_write,
   output logic                   out_rm4,
   output logic [VADDR_WIDTH-1:0] out_next_pc,
   output logic [REG_WIDTH-1:0]   out_ra_data,
   output logic [REG_WIDTH-1:0]   out_rb_data,
   output logic [REG_WIDTH-1:0]   out_offset,
   output logic [ID_W-1:0]        out_ra_id,
   output logic [ID_W-1:0]        out_rb_id,
   output logic [ID_W-1:0]        out_reg_dest,
   output logic [CNT_W-1:0]       hazard_stalls
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   typedef struct packed {
      logic [OP_W-1:0]        alu_op;
      logic                   use_reg_b;
      logic                   mem_write;
      logic                   mem_read;
      logic [MODE_W-1:0]      cache_mode;
      logic                   mem_to_reg;
      logic                   reg_write;
      logic                   tlb_write;
      logic                   rm4;
      logic [VADDR_WIDTH-1:0] next_pc;
      logic [REG_WIDTH-1:0]   ra_data;
      logic [REG_WIDTH-1:0]   rb_data;
      logic [REG_WIDTH-1:0]   offset;
      logic [ID_W-1:0]        ra_id;
      logic [ID_W-1:0]        rb_id;
      logic [ID_W-1:0]        reg_dest;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           in_entry;
   entry_t           head_entry;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;
   logic [PTR_W-1:0] slot;
   logic             uses_rb;
   logic             ex_hazard;
   logic             buf_hazard;
   logic             hazard;
   logic             push;
   logic             pop;

   assign in_entry = '{
      alu_op:     in_alu_op,
      use_reg_b:  in_use_reg_b,
      mem_write:  in_mem_write,
      mem_read:   in_mem_read,
      cache_mode: in_cache_mode,
      mem_to_reg: in_mem_to_reg,
      reg_write:  in_reg_write,
      tlb_write:  in_tlb_write,
      rm4:        in_rm4,
      next_pc:    in_next_pc,
      ra_data:    in_ra_data,
      rb_data:    in_rb_data,
      offset:     in_offset,
      ra_id:      in_ra_id,
      rb_id:      in_rb_id,
      reg_dest:   in_reg_dest
   };

   // A load in execute or anywhere in the buffer whose result the incoming instruction reads.
   always_comb begin
      uses_rb    = in_use_reg_b | in_mem_write;
      ex_hazard  = ex_valid && ex_mem_read &&
                   (ex_reg_dest == in_ra_id || (uses_rb && ex_reg_dest == in_rb_id));
      buf_hazard = 1'b0;
      slot       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot = PTR_W'(i) - head;
         if ({1'b0, slot} < count && mem[i].mem_read &&
             (mem[i].reg_dest == in_ra_id || (uses_rb && mem[i].reg_dest == in_rb_id)))
            buf_hazard = 1'b1;
      end
      hazard = ex_hazard || buf_hazard;
   end

   assign out_valid = (count != '0);
   assign in_ready  = rst_n && !flush && !hazard &&
                      (count < FULL_COUNT || (out_valid && out_ready));
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         hazard_stalls <= '0;
      end else begin
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
         if (in_valid && hazard && !flush && hazard_stalls != '1)
            hazard_stalls <= hazard_stalls + 1'b1;
      end
   end

   // NOTE: storage has no reset; count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= in_entry;
   end

   assign head_entry     = out_valid ? mem[head] : '0;
   assign out_alu_op     = head_entry.alu_op;
   assign out_use_reg_b  = head_entry.use_reg_b;
   assign out_mem_write  = head_entry.mem_write;
   assign out_mem_read   = head_entry.mem_read;
   assign out_cache_mode = head_entry.cache_mode;
   assign out_mem_to_reg = head_entry.mem_to_reg;
   assign out_reg_write  = head_entry.reg_write;
   assign out_tlb_write  = head_entry.tlb_write;
   assign out_rm4        = head_entry.rm4;
   assign out_next_pc    = head_entry.next_pc;
   assign out_ra_data    = head_entry.ra_data;
   assign out_rb_data    = head_entry.rb_data;
   assign out_offset     = head_entry.offset;
   assign out_ra_id      = head_entry.ra_id;
   assign out_rb_id      = head_entry.rb_id;
   assign out_reg_dest   = head_entry.reg_dest;

endmodule

// File: tb/tb_cpu_decode_execute_pipe.sv
// Bench for cpu_decode_execute_pipe: directed scenarios plus random traffic checked
// against a queue-based model of the stage.
module tb_cpu_decode_execute_pipe;

   localparam int RW = 32, VA = 32, NR = 32, NO = 16, MW = 2, DP = 2, CW = 4;
   localparam int IW = 5, OW = 4;

   typedef struct packed {
      logic [OW-1:0] alu_op;
      logic          use_reg_b;
      logic          mem_write;
      logic          mem_read;
      logic [MW-1:0] cache_mode;
      logic          mem_to_reg;
      logic          reg_write;
      logic          tlb_write;
      logic          rm4;
      logic [VA-1:0] next_pc;
      logic [RW-1:0] ra_data;
      logic [RW-1:0] rb_data;
      logic [RW-1:0] offset;
      logic [IW-1:0] ra_id;
      logic [IW-1:0] rb_id;
      logic [IW-1:0] reg_dest;
   } pl_t;

   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic ex_valid = 1'b0, ex_mem_read = 1'b0;
   logic [IW-1:0] ex_reg_dest = '0;
   pl_t din = '0;
   pl_t dout;
   logic in_ready, out_valid;
   logic [CW-1:0] hazard_stalls;
   logic [OW-1:0] out_alu_op;
   logic out_use_reg_b, out_mem_write, out_mem_read, out_mem_to_reg, out_reg_write;
   logic out_tlb_write, out_rm4;
   logic [MW-1:0] out_cache_mode;
   logic [VA-1:0] out_next_pc;
   logic [RW-1:0] out_ra_data, out_rb_data, out_offset;
   logic [IW-1:0] out_ra_id, out_rb_id, out_reg_dest;

   assign dout = {out_alu_op, out_use_reg_b, out_mem_write, out_mem_read, out_cache_mode,
                  out_mem_to_reg, out_reg_write, out_tlb_write, out_rm4, out_next_pc,
                  out_ra_data, out_rb_data, out_offset, out_ra_id, out_rb_id, out_reg_dest};

   cpu_decode_execute_pipe #(
      .REG_WIDTH(RW), .VADDR_WIDTH(VA), .NUM_REGS(NR), .NUM_ALU_OPS(NO),
      .MODE_W(MW), .DEPTH(DP), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_dest(ex_reg_dest),
      .in_alu_op(din.alu_op), .in_use_reg_b(din.use_reg_b), .in_mem_write(din.mem_write),
      .in_mem_read(din.mem_read), .in_cache_mode(din.cache_mode),
      .in_mem_to_reg(din.mem_to_reg), .in_reg_write(din.reg_write),
      .in_tlb_write(din.tlb_write), .in_rm4(din.rm4), .in_next_pc(din.next_pc),
      .in_ra_data(din.ra_data), .in_rb_data(din.rb_data), .in_offset(din.offset),
      .in_ra_id(din.ra_id), .in_rb_id(din.rb_id), .in_reg_dest(din.reg_dest),
      .out_alu_op(out_alu_op), .out_use_reg_b(out_use_reg_b), .out_mem_write(out_mem_write),
      .out_mem_read(out_mem_read), .out_cache_mode(out_cache_mode),
      .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
      .out_tlb_write(out_tlb_write), .out_rm4(out_rm4), .out_next_pc(out_next_pc),
      .out_ra_data(out_ra_data), .out_rb_data(out_rb_data), .out_offset(out_offset),
      .out_ra_id(out_ra_id), .out_rb_id(out_rb_id), .out_reg_dest(out_reg_dest),
      .hazard_stalls(hazard_stalls)
   );

   always #5 clk = ~clk;

   // Reference model: the buffered instructions in order, plus the stall count.
   pl_t q[$];
   int  m_stalls = 0;
   bit  exp_ready, obs_ready;
   int  total = 0, bad = 0;

   function automatic bit reads_reg(logic [IW-1:0] r, pl_t i);
      return (r == i.ra_id) || ((i.use_reg_b || i.mem_write) && r == i.rb_id);
   endfunction

   function automatic bit m_hazard();
      if (ex_valid && ex_mem_read && reads_reg(ex_reg_dest, din)) return 1'b1;
      foreach (q[k]) if (q[k].mem_read && reads_reg(q[k].reg_dest, din)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic pl_t m_head();
      return (q.size() > 0) ? q[0] : pl_t'('0);
   endfunction

   function automatic pl_t rand_pl();
      pl_t p;
      p.alu_op     = OW'($urandom);
      p.use_reg_b  = 1'($urandom);
      p.mem_write  = 1'($urandom);
      p.mem_read   = 1'($urandom);
      p.cache_mode = MW'($urandom);
      p.mem_to_reg = 1'($urandom);
      p.reg_write  = 1'($urandom);
      p.tlb_write  = 1'($urandom);
      p.rm4        = 1'($urandom);
      p.next_pc    = $urandom;
      p.ra_data    = $urandom;
      p.rb_data    = $urandom;
      p.offset     = $urandom;
      p.ra_id      = IW'($urandom_range(0, 3));
      p.rb_id      = IW'($urandom_range(0, 3));
      p.reg_dest   = IW'($urandom_range(0, 3));
      return p;
   endfunction

   // Inputs are driven just after a falling edge; one call advances one clock and the model.
   task automatic tick();
      bit hz;
      #1;
      hz        = m_hazard();
      exp_ready = !flush && !hz && (q.size() < DP || (q.size() > 0 && out_ready));
      obs_ready = in_ready;
      @(posedge clk);
      if (in_valid && hz && !flush && m_stalls < 2**CW - 1) m_stalls++;
      if (flush) q.delete();
      else begin
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (in_valid && exp_ready) q.push_back(din);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid = 0; flush = 0; ex_valid = 0; ex_mem_read = 0; out_ready = 1;
      repeat (DP + 1) tick();
   endtask

   task automatic test_reset();
      rst_n = 0; in_valid = 1; out_ready = 1; din = rand_pl();
      #1;
      total += 4;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      if (dout !== '0) begin bad++; $display("FAIL reset_payload: got %h want 0", dout); end
      if (hazard_stalls !== '0) begin bad++; $display("FAIL reset_stalls: got %0d want 0", hazard_stalls); end
      @(negedge clk); @(negedge clk);
      rst_n = 1; in_valid = 0;
      q.delete(); m_stalls = 0;
   endtask

   task automatic test_streaming();
      drain();
      for (int i = 0; i < 5; i++) begin
         din = rand_pl(); din.mem_read = 0; din.next_pc = VA'(32'h100 + 4 * i);
         in_valid = 1;
         tick();
         total += 2;
         if (obs_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d]: got %b want 1", i, obs_ready); end
         if (out_valid !== 1'b1 || out_next_pc !== VA'(32'h100 + 4 * i) || dout !== m_head()) begin
            bad++; $display("FAIL stream_head[%0d]: got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_next_pc, 32'h100 + 4 * i);
         end
      end
      in_valid = 0;
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      drain();
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         din = rand_pl(); din.mem_read = 0; din.next_pc = VA'(32'h100 + 4 * i);
         in_valid = 1;
         tick();
         total += 2;
         if (obs_ready !== (i < 2)) begin bad++; $display("FAIL bp_ready[%0d]: got %b want %b", i, obs_ready, i < 2); end
         if (out_next_pc !== 32'h100) begin bad++; $display("FAIL bp_hold[%0d]: got %h want 100", i, out_next_pc); end
      end
      out_ready = 1;
      tick();
      total += 2;
      if (obs_ready !== 1'b1) begin bad++; $display("FAIL bp_full_pushpop: got %b want 1", obs_ready); end
      if (out_next_pc !== 32'h104) begin bad++; $display("FAIL bp_order1: got %h want 104", out_next_pc); end
      in_valid = 0;
      tick();
      total++;
      if (out_next_pc !== 32'h108 || dout !== m_head()) begin bad++; $display("FAIL bp_order2: got %h want 108", out_next_pc); end
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_load_use_ex();
      drain();
      din = rand_pl(); din.ra_id = 5; din.mem_read = 0;
      ex_valid = 1; ex_mem_read = 1; ex_reg_dest = 5; in_valid = 1;
      tick();
      total += 3;
      if (obs_ready !== 1'b0) begin bad++; $display("FAIL luex_ready: got %b want 0", obs_ready); end
      if (hazard_stalls !== CW'(m_stalls) || m_stalls != 1) begin bad++; $display("FAIL luex_stalls: got %0d want 1", hazard_stalls); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL luex_bubble: got %b want 0", out_valid); end
      ex_valid = 0;
      tick();
      total += 2;
      if (obs_ready !== 1'b1) begin bad++; $display("FAIL luex_accept: got %b want 1", obs_ready); end
      if (out_valid !== 1'b1 || dout !== din) begin bad++; $display("FAIL luex_out: got %h want %h", dout, din); end
   endtask

   task automatic test_load_use_buf();
      drain();
      out_ready = 0;
      din = rand_pl(); din.mem_read = 1; din.reg_dest = 7; din.ra_id = 0; din.rb_id = 0;
      in_valid = 1;
      tick();
      din = rand_pl(); din.mem_read = 0; din.use_reg_b = 1; din.rb_id = 7; din.ra_id = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total += 2;
         if (obs_ready !== 1'b0) begin bad++; $display("FAIL lubuf_stall[%0d]: got %b want 0", i, obs_ready); end
         if (hazard_stalls !== CW'(m_stalls)) begin bad++; $display("FAIL lubuf_count[%0d]: got %0d want %0d", i, hazard_stalls, m_stalls); end
      end
      out_ready = 1;
      tick();
      total++;
      if (obs_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL lubuf_pop: got rdy=%b v=%b want 0 0", obs_ready, out_valid); end
      tick();
      total++;
      if (obs_ready !== 1'b1 || dout !== din) begin bad++; $display("FAIL lubuf_accept: got rdy=%b out=%h want 1 %h", obs_ready, dout, din); end
      drain();
      out_ready = 0;
      din = rand_pl(); din.mem_read = 1; din.reg_dest = 7; din.ra_id = 0; din.rb_id = 0;
      tick();
      din = rand_pl(); din.mem_read = 0; din.use_reg_b = 0; din.mem_write = 0; din.rb_id = 7; din.ra_id = 1;
      tick();
      total++;
      if (obs_ready !== 1'b1) begin bad++; $display("FAIL lubuf_no_rb: got %b want 1", obs_ready); end
   endtask

   task automatic test_flush();
      int s;
      drain();
      out_ready = 0; in_valid = 1;
      repeat (2) begin din = rand_pl(); din.mem_read = 0; tick(); end
      din = rand_pl(); din.mem_read = 0;
      flush = 1; out_ready = 1; s = m_stalls;
      tick();
      total += 3;
      if (obs_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", obs_ready); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty: got %b want 0", out_valid); end
      if (hazard_stalls !== CW'(s)) begin bad++; $display("FAIL flush_stalls: got %0d want %0d", hazard_stalls, s); end
      flush = 0; in_valid = 0;
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop_input: got %b want 0", out_valid); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         flush       = ($urandom_range(0, 19) == 0);
         ex_valid    = 1'($urandom);
         ex_mem_read = 1'($urandom);
         ex_reg_dest = IW'($urandom_range(0, 3));
         din         = rand_pl();
         tick();
         total += 4;
         if (obs_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, obs_ready, exp_ready); end
         if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, q.size() != 0); end
         if (dout !== m_head()) begin bad++; $display("FAIL rnd_payload[%0d]: got %h want %h", n, dout, m_head()); end
         if (hazard_stalls !== CW'(m_stalls)) begin bad++; $display("FAIL rnd_stalls[%0d]: got %0d want %0d", n, hazard_stalls, m_stalls); end
      end
   endtask

   task automatic test_saturation_reset();
      drain();
      din = rand_pl(); din.ra_id = 9;
      ex_valid = 1; ex_mem_read = 1; ex_reg_dest = 9; in_valid = 1;
      repeat (20) tick();
      total++;
      if (hazard_stalls !== 4'd15) begin bad++; $display("FAIL sat_count: got %0d want 15", hazard_stalls); end
      ex_valid = 0; out_ready = 0;
      din = rand_pl(); din.mem_read = 0;
      repeat (2) tick();
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL sat_buffered: got %b want 1", out_valid); end
      #2 rst_n = 0;
      #1;
      total += 4;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", out_valid); end
      if (dout !== '0) begin bad++; $display("FAIL arst_payload: got %h want 0", dout); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL arst_ready: got %b want 0", in_ready); end
      if (hazard_stalls !== '0) begin bad++; $display("FAIL arst_stalls: got %0d want 0", hazard_stalls); end
      q.delete(); m_stalls = 0;
      @(negedge clk);
      rst_n = 1; in_valid = 0;
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_after: got %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_load_use_ex();
      test_load_use_buf();
      test_flush();
      test_random();
      test_saturation_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_decode_execute_pipe.md
Name: cpu_decode_execute_pipe

Overview:
- Parametrised decode→execute pipeline boundary: a buffered stage register with valid/ready handshake on both sides.
- Holds the full execute/commit/writeback bundle (ALU op, operand select, memory control, cache mode, writeback control, TLB write, rm4, next PC, operands, register ids).
- Adds what a plain bundle lacks:
  - DEPTH-entry skid FIFO;
  - load-use hazard bubble insertion;
  - synchronous flush from branch/exception resolution;
  - a saturating hazard-stall counter.

Parameters:
- REG_WIDTH, 32, operand/offset data width.
- VADDR_WIDTH, 32, next-PC width.
- NUM_REGS, 32, register count; ID_W = clog2(NUM_REGS).
- NUM_ALU_OPS, 16, ALU op count; OP_W = clog2(NUM_ALU_OPS).
- MODE_W, 2, cache_mode field width.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all buffered entries and the current input.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- out_valid  out  1  head entry valid toward execute.
- out_ready  in  1  execute consumes head.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_mem_read  in  1  that instruction is a load.
- ex_reg_dest  in  ID_W  its destination register.
- in_/out_alu_op  in/out  OP_W  ALU op.
- in_/out_use_reg_b  in/out  1  B-operand select.
- in_/out_mem_write, in_/out_mem_read  in/out  1 each  memory control.
- in_/out_cache_mode  in/out  MODE_W  cache mode.
- in_/out_mem_to_reg, in_/out_reg_write  in/out  1 each  writeback control.
- in_/out_tlb_write, in_/out_rm4  in/out  1 each  TLB write, rm4.
- in_/out_next_pc  in/out  VADDR_WIDTH  next PC.
- in_/out_ra_data, in_/out_rb_data, in_/out_offset  in/out  REG_WIDTH  operands/offset.
- in_/out_ra_id, in_/out_rb_id, in_/out_reg_dest  in/out  ID_W  register ids.
- hazard_stalls  out  CNT_W  cycles stalled by hazard, saturating.

Behaviour:
- Reset (rst_n=0, async):
  - FIFO empty, head/tail/count = 0.
  - out_valid=0, hazard_stalls=0.
  - in_ready=0 while reset is asserted.
  - All out_* payload = 0.
- Storage and ordering:
  - Circular FIFO with head/tail pointers of clog2(DEPTH) bits, wrapping modulo DEPTH; count is clog2(DEPTH)+1 bits.
  - out_* is driven from the head entry, so it is registered.
  - out_* payload reads 0 when empty.
  - Latency: an entry accepted in cycle N is visible at out_* in cycle N+1.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Allowed when full: in_ready is combinationally true if out_ready pops.
- hazard is a combinational OR of two sources:
  - ex_valid && ex_mem_read && (ex_reg_dest==in_ra_id || (in_use_reg_b|in_mem_write) && ex_reg_dest==in_rb_id);
  - any valid FIFO entry with mem_read=1 whose reg_dest matches by the same rule.
  - No register-0 exclusion.
- in_ready = !flush && !hazard && (count<DEPTH || (out_valid && out_ready)).
- Bubble insertion:
  - When hazard=1, the instruction is held upstream.
  - Execute is unaffected and keeps draining; the bubble is the absence of a push.
- hazard_stalls increments by 1 in each cycle with in_valid && hazard && !flush, and saturates at 2^CNT_W-1.
- Flush:
  - Synchronous. The next edge sets count=0 and head=tail=0.
  - No push that cycle; a pop handshake in the flush cycle is ignored, and the entry is discarded anyway.
  - out_valid=0 from the following cycle.
  - hazard_stalls is not cleared.
- Input/output stability:
  - in_* are sampled only on push.
  - out_* stay stable while out_valid && !out_ready.
- Reset mid-operation discards all entries immediately. The stall counter is cleared only by reset.

Test Plan:
- Streaming: out_ready=1, 5 back-to-back instructions, next_pc 0x100..0x110 step 4 → each appears one cycle after accept, in order, in_ready stays 1.
- Backpressure/full: DEPTH=2, out_ready=0, push 3 → third blocked (in_ready=0, count=2). Raise out_ready → pop and push in the same cycle; order 0x100, 0x104, 0x108 preserved.
- Load-use against execute: ex_valid=1, ex_mem_read=1, ex_reg_dest=5, incoming ra_id=5 → in_ready=0, hazard_stalls=1. Drop ex_valid next cycle → accepted.
- Load-use against buffer: buffered load to r7 with out_ready=0; incoming use_reg_b=1, rb_id=7 → stall each cycle. Pop load → accepted. Same with use_reg_b=0, mem_write=0, rb_id=7 → no stall.
- Flush: 2 entries buffered, flush=1 with in_valid=1 → next cycle out_valid=0, count 0, input not taken, hazard_stalls unchanged.
- Saturation/reset: CNT_W=4, hold a hazard 20 cycles → counter 15. Drop rst_n mid-burst → all outputs 0 asynchronously.
